// File: rtl/regfile_wb_queue_pkg.sv
// Shared sizes and the queued write-back entry type for the register-file
// write-back queue.
package regfile_wb_pkg;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNTW  = $clog2(DEPTH) + 1;
  localparam int unsigned NREG  = 2 ** AW;

  typedef struct packed {
    logic [AW-1:0] dr;
    logic [DW-1:0] data;
  } entry_t;
endpackage

// File: rtl/regfile_wb_queue_if.sv
// Producer handshakes, register-file write port and hazard outputs of the
// write-back queue, bundled for the top-level port list.
interface regfile_wb_queue_if;
  import regfile_wb_pkg::*;

  logic            a_valid;
  logic            a_ready;
  logic [AW-1:0]   a_dr;
  logic [DW-1:0]   a_data;
  logic            b_valid;
  logic            b_ready;
  logic [AW-1:0]   b_dr;
  logic [DW-1:0]   b_data;
  logic            hold;
  logic            write;
  logic [AW-1:0]   dr;
  logic [DW-1:0]   wrData;
  logic [NREG-1:0] pending;
  logic [CNTW-1:0] count;

  modport master (
    output a_valid, a_dr, a_data, b_valid, b_dr, b_data, hold,
    input  a_ready, b_ready, write, dr, wrData, pending, count
  );

  modport slave (
    input  a_valid, a_dr, a_data, b_valid, b_dr, b_data, hold,
    output a_ready, b_ready, write, dr, wrData, pending, count
  );
endinterface

// File: rtl/regfile_wb_queue_wb_fifo.sv
// Synchronous FIFO of write-back entries; exposes per-slot valid bits and
// destinations so the top can build the pending-register vector.
module wb_fifo
  import regfile_wb_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  entry_t                     din,
  output entry_t                     head,
  output logic [CNTW-1:0]            count,
  output logic [DEPTH-1:0]           vld,
  output logic [DEPTH-1:0][AW-1:0]   ent_dr
);
  localparam int unsigned PW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [CNTW-1:0] cnt;
  logic            do_pop;
  logic            do_push;

  // A full FIFO may still accept when the head leaves on the same edge.
  assign do_pop  = pop && (cnt != '0);
  assign do_push = push && ((cnt != CNTW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      vld  <= '0;
    end else begin
      if (do_pop) begin
        rptr      <= rptr + PW'(1);
        vld[rptr] <= 1'b0;
      end
      if (do_push) begin
        wptr      <= wptr + PW'(1);
        vld[wptr] <= 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNTW'(1);
        2'b01:   cnt <= cnt - CNTW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_dr[i] = mem[i].dr;
  end

  assign head  = mem[rptr];
  assign count = cnt;
endmodule

// File: rtl/regfile_wb_queue.sv
// Write-back queue in front of the register-file write port: round-robin
// arbitration of ALU (A) and load (B) results, FIFO, output register, hazards.
module regfile_wb_queue
  import regfile_wb_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  regfile_wb_queue_if.slave  bus
);
  logic [CNTW-1:0]          count;
  logic [DEPTH-1:0]         vld;
  logic [DEPTH-1:0][AW-1:0] ent_dr;
  entry_t                   head;
  entry_t                   din;
  logic                     pop;
  logic                     space;
  logic                     a_rdy;
  logic                     b_rdy;
  logic                     a_fire;
  logic                     b_fire;
  logic                     last_b;
  logic                     write_p1;
  logic [AW-1:0]            dr_p1;
  logic [DW-1:0]            data_p1;
  logic [NREG-1:0]          pending;

  assign pop   = (count != '0) && !bus.hold;
  assign space = (count < CNTW'(DEPTH)) || pop;

  // Ready depends only on the other source's valid, never on own dr/data.
  assign a_rdy  = reset && space && (!bus.b_valid || last_b);
  assign b_rdy  = reset && space && (!bus.a_valid || !last_b);
  assign a_fire = bus.a_valid && a_rdy;
  assign b_fire = bus.b_valid && b_rdy;
  assign din    = a_fire ? entry_t'{dr: bus.a_dr, data: bus.a_data}
                         : entry_t'{dr: bus.b_dr, data: bus.b_data};

  always_ff @(posedge clk) begin
    if (!reset)      last_b <= 1'b1;
    else if (a_fire) last_b <= 1'b0;
    else if (b_fire) last_b <= 1'b1;
  end

  wb_fifo u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (a_fire || b_fire),
    .pop    (pop),
    .din    (din),
    .head   (head),
    .count  (count),
    .vld    (vld),
    .ent_dr (ent_dr)
  );

  // p1: register-file write port register
  always_ff @(posedge clk) begin
    if (!reset) begin
      write_p1 <= 1'b0;
      dr_p1    <= '0;
      data_p1  <= '0;
    end else begin
      write_p1 <= pop;
      if (pop) begin
        dr_p1   <= head.dr;
        data_p1 <= head.data;
      end
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i]) pending[ent_dr[i]] = 1'b1;
    end
    if (write_p1) pending[dr_p1] = 1'b1;
  end

  assign bus.a_ready = a_rdy;
  assign bus.b_ready = b_rdy;
  assign bus.write   = write_p1;
  assign bus.dr      = dr_p1;
  assign bus.wrData  = data_p1;
  assign bus.pending = pending;
  assign bus.count   = count;
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_regfile_wb_queue;
  import regfile_wb_pkg::*;

  typedef struct {
    logic [AW-1:0] dr;
    logic [DW-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_queue_if bus ();
  regfile_wb_queue dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  ent_t          q[$];
  bit            m_lastb = 1'b1;
  logic          m_write = 1'b0;
  logic [AW-1:0] m_dr = '0;
  logic [DW-1:0] m_data = '0;
  bit            m_pop, m_afire, m_bfire;
  ent_t          m_aent, m_bent;
  logic [DW-1:0] rf [NREG];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [NREG-1:0] exp_pending();
    logic [NREG-1:0] p = '0;
    foreach (q[i]) p[q[i].dr] = 1'b1;
    if (m_write) p[m_dr] = 1'b1;
    return p;
  endfunction

  // Evaluate the model at the negedge, compare, then advance it at the posedge.
  task automatic cycle();
    bit sp, ea, eb;
    @(negedge clk);
    m_pop = (q.size() > 0) && !bus.hold;
    sp    = (q.size() < DEPTH) || m_pop;
    ea    = reset && sp && (!bus.b_valid || m_lastb);
    eb    = reset && sp && (!bus.a_valid || !m_lastb);
    m_afire = bus.a_valid && ea;
    m_bfire = bus.b_valid && eb;
    m_aent  = '{bus.a_dr, bus.a_data};
    m_bent  = '{bus.b_dr, bus.b_data};
    chk("a_ready", 64'(bus.a_ready), 64'(ea));
    chk("b_ready", 64'(bus.b_ready), 64'(eb));
    chk("count", 64'(bus.count), 64'(q.size()));
    chk("write", 64'(bus.write), 64'(m_write));
    chk("dr", 64'(bus.dr), 64'(m_dr));
    chk("wrData", 64'(bus.wrData), 64'(m_data));
    chk("pending", 64'(bus.pending), 64'(exp_pending()));
    if (bus.write === 1'b1) rf[bus.dr] = bus.wrData;
    @(posedge clk);
    if (!reset) begin
      q.delete();
      m_write = 1'b0; m_dr = '0; m_data = '0; m_lastb = 1'b1;
    end else begin
      if (m_pop) begin
        m_write = 1'b1; m_dr = q[0].dr; m_data = q[0].data;
        void'(q.pop_front());
      end else begin
        m_write = 1'b0;
      end
      if (m_afire) begin q.push_back(m_aent); m_lastb = 1'b0; end
      else if (m_bfire) begin q.push_back(m_bent); m_lastb = 1'b1; end
    end
    #1;
  endtask

  task automatic send_a(input int d, input int v);
    bit ok = 1'b0;
    bus.a_valid = 1'b1; bus.a_dr = AW'(d); bus.a_data = DW'(v);
    for (int n = 0; n < 20 && !ok; n++) begin cycle(); ok = m_afire; end
    chk("send_a_accept", 64'(ok), 64'd1);
    bus.a_valid = 1'b0;
  endtask

  task automatic send_b(input int d, input int v);
    bit ok = 1'b0;
    bus.b_valid = 1'b1; bus.b_dr = AW'(d); bus.b_data = DW'(v);
    for (int n = 0; n < 20 && !ok; n++) begin cycle(); ok = m_bfire; end
    chk("send_b_accept", 64'(ok), 64'd1);
    bus.b_valid = 1'b0;
  endtask

  initial begin
    int ai, bi, n;
    bus.a_valid = 1'b0; bus.a_dr = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_dr = '0; bus.b_data = '0;
    bus.hold = 1'b0;
    for (int i = 0; i < NREG; i++) rf[i] = '1;
    @(posedge clk);
    #1;

    // Reset held with A requesting
    bus.a_valid = 1'b1; bus.a_dr = AW'(1); bus.a_data = DW'(11);
    cycle(); cycle();
    chk("rst_a_ready", 64'(bus.a_ready), 64'd0);
    chk("rst_write", 64'(bus.write), 64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_pending", 64'(bus.pending), 64'd0);
    reset = 1'b1;
    cycle();
    chk("rst_release_accept", 64'(bus.count), 64'd1);
    bus.a_valid = 1'b0;
    repeat (3) cycle();

    // Single path: dr=3, data=30
    bus.a_valid = 1'b1; bus.a_dr = AW'(3); bus.a_data = DW'(30);
    cycle();
    bus.a_valid = 1'b0;
    chk("single_count", 64'(bus.count), 64'd1);
    chk("single_pend_q", 64'(bus.pending[3]), 64'd1);
    chk("single_write0", 64'(bus.write), 64'd0);
    cycle();
    chk("single_write1", 64'(bus.write), 64'd1);
    chk("single_dr", 64'(bus.dr), 64'd3);
    chk("single_data", 64'(bus.wrData), 64'd30);
    chk("single_pend_out", 64'(bus.pending[3]), 64'd1);
    cycle();
    chk("single_write_drop", 64'(bus.write), 64'd0);
    chk("single_pend_clr", 64'(bus.pending[3]), 64'd0);

    // Round-robin: A even registers, B odd registers, both always requesting
    ai = 0; bi = 1; n = 0;
    while ((ai < 32 || bi < 32) && n < 200) begin
      bus.a_valid = (ai < 32); bus.a_dr = AW'(ai); bus.a_data = DW'(10 * ai);
      bus.b_valid = (bi < 32); bus.b_dr = AW'(bi); bus.b_data = DW'(10 * bi);
      cycle();
      if (m_afire) ai += 2;
      if (m_bfire) bi += 2;
      n++;
    end
    chk("rr_done", 64'(n < 200), 64'd1);
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    repeat (6) cycle();
    for (int i = 0; i < 32; i++) chk("rf_readback", 64'(rf[i]), 64'(10 * i));

    // Full with hold: 4 accepted, 5th refused, then 4 ordered writes
    bus.hold = 1'b1;
    for (int k = 0; k < 4; k++) send_a(10 + k, 100 + k);
    bus.a_valid = 1'b1; bus.a_dr = AW'(14); bus.a_data = DW'(104);
    cycle(); cycle();
    chk("full_count", 64'(bus.count), 64'd4);
    chk("full_a_ready", 64'(bus.a_ready), 64'd0);
    bus.a_valid = 1'b0; bus.hold = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("drain_write", 64'(bus.write), 64'd1);
      chk("drain_dr", 64'(bus.dr), 64'(10 + k));
      chk("drain_data", 64'(bus.wrData), 64'(100 + k));
    end
    cycle();
    chk("drain_done", 64'(bus.write), 64'd0);

    // Push and pop on the same edge at full occupancy
    bus.hold = 1'b1;
    for (int k = 0; k < 4; k++) send_a(20 + k, 200 + k);
    bus.a_valid = 1'b1; bus.a_dr = AW'(24); bus.a_data = DW'(204);
    #1;
    chk("pp_ready_held", 64'(bus.a_ready), 64'd0);
    bus.hold = 1'b0;
    #1;
    chk("pp_ready_pop", 64'(bus.a_ready), 64'd1);
    cycle();
    bus.a_valid = 1'b0;
    chk("pp_count", 64'(bus.count), 64'd4);
    chk("pp_dr0", 64'(bus.dr), 64'd20);
    for (int k = 1; k < 5; k++) begin
      cycle();
      chk("pp_order", 64'(bus.dr), 64'(20 + k));
    end
    cycle();
    chk("pp_empty", 64'(bus.count), 64'd0);

    // Duplicate destination register 7
    bus.hold = 1'b1;
    send_a(7, 1);
    send_b(7, 2);
    bus.hold = 1'b0;
    cycle();
    chk("dup_first", 64'(bus.wrData), 64'd1);
    chk("dup_pend1", 64'(bus.pending[7]), 64'd1);
    cycle();
    chk("dup_second", 64'(bus.wrData), 64'd2);
    chk("dup_pend2", 64'(bus.pending[7]), 64'd1);
    cycle();
    chk("dup_pend_clr", 64'(bus.pending[7]), 64'd0);

    // Reset with three queued entries
    bus.hold = 1'b1;
    send_a(1, 5); send_b(2, 6); send_a(3, 7);
    chk("mid_count", 64'(bus.count), 64'd3);
    reset = 1'b0; bus.hold = 1'b0;
    cycle();
    chk("mid_rst_count", 64'(bus.count), 64'd0);
    chk("mid_rst_pending", 64'(bus.pending), 64'd0);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("mid_rst_nowrite", 64'(bus.write), 64'd0);
    end

    // Random traffic with holds and occasional resets
    for (int c = 0; c < 800; c++) begin
      if (!bus.a_valid && $urandom_range(0, 2) != 0) begin
        bus.a_valid = 1'b1; bus.a_dr = AW'($urandom); bus.a_data = $urandom;
      end
      if (!bus.b_valid && $urandom_range(0, 2) != 0) begin
        bus.b_valid = 1'b1; bus.b_dr = AW'($urandom); bus.b_data = $urandom;
      end
      bus.hold = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 99) != 0);
      cycle();
      if (m_afire) bus.a_valid = 1'b0;
      if (m_bfire) bus.b_valid = 1'b0;
    end
    reset = 1'b1; bus.hold = 1'b0; bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    repeat (8) cycle();
    chk("final_empty", 64'(bus.count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
Write-back queue sitting directly upstream of the 32x32 register file's single write port (write/dr/wrData). It accepts register-write requests from two producers (A = ALU result, B = load result) over valid/ready handshakes and arbitrates them round-robin into a small FIFO. It drains at most one entry per cycle into the register file. It also exports a per-register pending vector for hazard checking by the issue logic.

Parameters:
DEPTH, 4, FIFO entries (power of two, >= 2)
AW, 5, register address width (32 registers)
DW, 32, data width

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset (sampled on rising clk; 0 = reset)
a_valid  input  1  producer A request
a_ready  output  1  A accepted this cycle
a_dr  input  AW  A destination register
a_data  input  DW  A write data
b_valid  input  1  producer B request
b_ready  output  1  B accepted this cycle
b_dr  input  AW  B destination register
b_data  input  DW  B write data
hold  input  1  register-file write port unavailable; suppresses drain
write  output  1  register-file write enable (registered)
dr  output  AW  register-file destination (registered)
wrData  output  DW  register-file write data (registered)
pending  output  2**AW  bit r = 1 while a write to register r is queued or on the output
count  output  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (reset==0 at a clk edge): FIFO emptied, count=0, write=0, dr=0, wrData=0, pending=0, round-robin pointer set so A wins the first tie. a_ready=b_ready=0 while reset==0. Reset mid-operation discards all queued entries; none reach the register file.
- Space: space = (count < DEPTH) OR pop_this_cycle. Pushes are limited to one per cycle.
- Arbitration (combinational): only A valid -> a_ready=space; only B valid -> b_ready=space. Both valid -> grant goes to the source not granted last; the loser's ready is 0 and it must hold valid/dr/data stable. Pointer updates only on an actual grant.
- Handshake: transfer occurs when valid && ready at the clk edge. Ready never depends on the same source's dr or data.
- Drain: pop_this_cycle = (count > 0) && !hold. On a pop edge, the head entry is loaded into dr/wrData and write=1 for exactly the following cycle. Otherwise write=0; dr/wrData hold their last values.
- Latency: an entry accepted at edge t into an empty FIFO with hold=0 drives write=1 in the cycle after edge t+1. Order is FIFO order.
- Push and pop on the same edge: both occur. count unchanged. Allowed even when count==DEPTH.
- Full with hold=1: a_ready=b_ready=0; no loss.
- Empty: write=0 next cycle; hold is ignored.
- pending: OR over valid FIFO entries plus (write ? dr : none), decoded one-hot. Multiple entries to the same register are legal; the bit stays 1 until the last one leaves the output stage. No coalescing; register 0 is written like any other.
- Pointers wrap modulo DEPTH. count is exact; no overflow or underflow under any input sequence.

Decomposition:
- Package regfile_wb_pkg: AW, DW, DEPTH defaults; entry type {dr[AW], data[DW]}; CNTW = clog2(DEPTH)+1.
- Sub-module wb_fifo: synchronous FIFO of entries (push, pop, head, count, per-entry valid vector exposed for pending decode).
- Top module holds the round-robin arbiter, output register and pending decode.

Test Plan:
- Reset: hold reset=0 for 2 edges with a_valid=1 -> a_ready=0, write=0, count=0, pending=0; release -> first A request accepted.
- Single path: A sends (dr=3, data=30) with hold=0 -> write=1, dr=3, wrData=30 exactly one cycle, 2 edges after acceptance; pending[3]=1 from acceptance until write drops.
- Round-robin: A and B valid continuously with dr=i, data=10*i for i=0..31 (A even, B odd) -> grants alternate A,B,A,...; register-file readback gives reg(i)=10*i for all 32.
- Full/hold: hold=1, push 5 requests -> 4 accepted, count=4, ready=0 on 5th; release hold -> 4 writes on consecutive cycles in order, then 5th accepted.
- Simultaneous push/pop at count=DEPTH: hold drops while A is valid -> push and pop on the same edge, count stays 4, no entry lost or duplicated.
- Duplicate target plus mid-operation reset: queue two writes to dr=7 -> pending[7] stays 1 until the second write. Assert reset with 3 entries queued -> no further write pulses, pending=0.
